// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: d = a - b - bin, LSB first.
// One full-subtractor cell and a borrow flop, start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             ai, bi, di, br_nx;
  logic [WIDTH-1:0] r_nx;

  always_comb begin
    ai    = a_sh_q[0];
    bi    = b_sh_q[0];
    di    = ai ^ bi ^ br_q;
    br_nx = (~ai & bi) | (~(ai ^ bi) & br_q);
    r_nx  = {di, r_sh_q[WIDTH-1:1]};

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    res_d   = res_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_sh_d = r_nx;
        br_d   = br_nx;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // ai/bi are the operand sign bits on this final step
          state_d = DONE;
          done_d  = 1'b1;
          res_d   = r_nx;
          bout_d  = br_nx;
          ovf_d   = (ai != bi) & (di != ai);
          zero_d  = ~|r_nx;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = res_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
